// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ sequencer: icodes, status codes, FSM states.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExecute,
      StMemory,
      StWriteback,
      StPcupd,
      StHalted
   } state_e;

   function automatic logic is_mem_icode(input logic [3:0] ic);
      logic r;
      case (ic)
         I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
         default:                                          r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC selection for the SEQ core; pure muxing, no arithmetic.
module seq_next_pc
   import y86_pkg::*;
#(
   parameter int unsigned ADDR_W = 64
) (
   input  logic [3:0]        icode,
   input  logic              cnd,
   input  logic [ADDR_W-1:0] valC,
   input  logic [ADDR_W-1:0] valP,
   input  logic [ADDR_W-1:0] valM,
   output logic [ADDR_W-1:0] next_pc
);

   always_comb begin
      next_pc = valP;
      case (icode)
         I_JXX:   next_pc = cnd ? valC : valP;
         I_CALL:  next_pc = valC;
         I_RET:   next_pc = valM;
         default: next_pc = valP;
      endcase
   end

endmodule

// File: rtl/seq_stage_controller.sv
// SEQ Y86-64 multi-cycle sequencer: stage enables, data-memory handshake, PC and status.
module seq_stage_controller
   import y86_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 64,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int unsigned       MEM_TIMEOUT = 16,
   parameter int unsigned       CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        icode,
   input  logic              instr_valid,
   input  logic              imem_error,
   input  logic              cnd,
   input  logic [ADDR_W-1:0] valC,
   input  logic [ADDR_W-1:0] valP,
   input  logic [ADDR_W-1:0] valM,
   input  logic              mem_ack,
   input  logic              dmem_error,
   output logic              fetch_en,
   output logic              decode_en,
   output logic              execute_en,
   output logic              memory_en,
   output logic              writeback_en,
   output logic              pcupd_en,
   output logic              mem_req,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        stat,
   output logic              halted,
   output logic              busy,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [2:0]        stat_q, stat_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [ADDR_W-1:0] pc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] next_pc;
   logic              pc_load;

   seq_next_pc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc (
      .icode   (icode),
      .cnd     (cnd),
      .valC    (valC),
      .valP    (valP),
      .valM    (valM),
      .next_pc (next_pc)
   );

   always_comb begin
      state_d      = state_q;
      stat_d       = stat_q;
      tmo_d        = '0;
      pc_load      = 1'b0;
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      execute_en   = 1'b0;
      memory_en    = 1'b0;
      writeback_en = 1'b0;
      pcupd_en     = 1'b0;
      mem_req      = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            fetch_en = 1'b1;
            if (imem_error) begin
               stat_d  = STAT_ADR;
               state_d = StHalted;
            end else if (!instr_valid) begin
               stat_d  = STAT_INS;
               state_d = StHalted;
            end else if (icode == I_HALT) begin
               stat_d  = STAT_HLT;
               state_d = StHalted;
            end else begin
               state_d = StDecode;
            end
         end
         StDecode: begin
            decode_en = 1'b1;
            state_d   = StExecute;
         end
         StExecute: begin
            execute_en = 1'b1;
            state_d    = StMemory;
         end
         StMemory: begin
            memory_en = 1'b1;
            if (is_mem_icode(icode)) begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  if (dmem_error) begin
                     stat_d  = STAT_ADR;
                     state_d = StHalted;
                  end else begin
                     state_d = StWriteback;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  // Last permitted wait cycle passed without an ack.
                  stat_d  = STAT_ADR;
                  state_d = StHalted;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end else begin
               state_d = StWriteback;
            end
         end
         StWriteback: begin
            writeback_en = 1'b1;
            state_d      = StPcupd;
         end
         StPcupd: begin
            pcupd_en = 1'b1;
            pc_load  = 1'b1;
            state_d  = StFetch;
         end
         StHalted: begin
            state_d = StHalted;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         stat_q  <= STAT_AOK;
         tmo_q   <= '0;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
         tmo_q   <= tmo_d;
         if (pc_load) begin
            pc_q  <= next_pc;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // stat_q only leaves AOK on entry to HALTED, which is left only by reset.
   assign stat        = stat_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;
   assign halted      = (state_q == StHalted);
   assign busy        = (state_q != StIdle) && (state_q != StHalted);

endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized self-checking bench for seq_stage_controller against a stage-sequence model.
module tb_seq_stage_controller;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  icode;
   logic        instr_valid;
   logic        imem_error;
   logic        cnd;
   logic [63:0] valC, valP, valM;
   logic        mem_ack;
   logic        dmem_error;
   logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en;
   logic        mem_req;
   logic [63:0] pc;
   logic [2:0]  stat;
   logic        halted, busy;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [63:0] m_pc;
   logic [31:0] m_cnt;
   logic [2:0]  m_stat;
   logic        m_halted;

   seq_stage_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .icode        (icode),
      .instr_valid  (instr_valid),
      .imem_error   (imem_error),
      .cnd          (cnd),
      .valC         (valC),
      .valP         (valP),
      .valM         (valM),
      .mem_ack      (mem_ack),
      .dmem_error   (dmem_error),
      .fetch_en     (fetch_en),
      .decode_en    (decode_en),
      .execute_en   (execute_en),
      .memory_en    (memory_en),
      .writeback_en (writeback_en),
      .pcupd_en     (pcupd_en),
      .mem_req      (mem_req),
      .pc           (pc),
      .stat         (stat),
      .halted       (halted),
      .busy         (busy),
      .instr_count  (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compare every output against the model; exp_en bit k is stage k (fetch..pcupd).
   task automatic chk_cycle(input string tag, input logic [5:0] exp_en, input logic exp_mreq);
      chk({tag, "/en"}, 64'({pcupd_en, writeback_en, memory_en, execute_en, decode_en,
                            fetch_en}), 64'(exp_en));
      chk({tag, "/mem_req"}, 64'(mem_req), 64'(exp_mreq));
      chk({tag, "/busy"}, 64'(busy), 64'(exp_en != 6'd0));
      chk({tag, "/halted"}, 64'(halted), 64'(m_halted));
      chk({tag, "/stat"}, 64'(stat), 64'(m_halted ? m_stat : 3'd1));
      chk({tag, "/pc"}, pc, m_pc);
      chk({tag, "/count"}, 64'(instr_count), 64'(m_cnt));
   endtask

   function automatic logic [63:0] ref_next(input logic [3:0] ic, input logic c,
                                            input logic [63:0] vc, input logic [63:0] vp,
                                            input logic [63:0] vm);
      if (ic == 4'h7) return c ? vc : vp;
      if (ic == 4'h8) return vc;
      if (ic == 4'h9) return vm;
      return vp;
   endfunction

   function automatic logic ref_is_mem(input logic [3:0] ic);
      return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
             (ic == 4'hA) || (ic == 4'hB);
   endfunction

   // Reset (optionally mid-cycle, with no clock edge before the check), then start.
   task automatic do_reset(input logic mid);
      if (mid) #2;
      rst_n = 1'b0;
      #1;
      m_pc = 64'h0; m_cnt = 32'h0; m_stat = 3'd1; m_halted = 1'b0;
      chk_cycle("reset", 6'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      tick();
      chk_cycle("idle", 6'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Entered at a negedge with the DUT in FETCH; leaves at the next FETCH or in HALTED.
   task automatic do_instr(input logic [3:0] ic, input logic iv, input logic ime,
                           input logic c, input logic [63:0] vc, input logic [63:0] vp,
                           input logic [63:0] vm, input int wt, input logic de,
                           input logic never);
      icode = ic; instr_valid = iv; imem_error = ime; cnd = c;
      valC = vc; valP = vp; valM = vm; mem_ack = 1'b0; dmem_error = 1'b0;
      #1;
      chk_cycle("fetch", 6'b000001, 1'b0);
      if (ime || !iv || ic == 4'h0) begin
         m_stat = ime ? 3'd3 : (!iv ? 3'd4 : 3'd2);
         m_halted = 1'b1;
         tick();
         imem_error = 1'b0; instr_valid = 1'b1;
         chk_cycle("fetch_fault", 6'd0, 1'b0);
         return;
      end
      tick();
      chk_cycle("decode", 6'b000010, 1'b0);
      tick();
      chk_cycle("execute", 6'b000100, 1'b0);
      tick();
      if (ref_is_mem(ic)) begin
         if (never) begin
            for (int k = 0; k < 16; k++) begin
               dmem_error = 1'($urandom);
               chk_cycle("mem_wait", 6'b001000, 1'b1);
               tick();
            end
            m_stat = 3'd3; m_halted = 1'b1;
            chk_cycle("mem_timeout", 6'd0, 1'b0);
            dmem_error = 1'b0;
            return;
         end
         for (int k = 0; k <= wt; k++) begin
            mem_ack = (k == wt);
            dmem_error = (k == wt) ? de : 1'($urandom);
            chk_cycle("mem", 6'b001000, 1'b1);
            tick();
         end
         mem_ack = 1'b0; dmem_error = 1'b0;
         if (de) begin
            m_stat = 3'd3; m_halted = 1'b1;
            chk_cycle("dmem_fault", 6'd0, 1'b0);
            return;
         end
      end else begin
         // Ack is meaningless without a request and must be ignored.
         mem_ack = 1'($urandom); dmem_error = 1'($urandom);
         chk_cycle("mem_none", 6'b001000, 1'b0);
         tick();
         mem_ack = 1'b0; dmem_error = 1'b0;
      end
      chk_cycle("writeback", 6'b010000, 1'b0);
      tick();
      chk_cycle("pcupd", 6'b100000, 1'b0);
      tick();
      m_pc = ref_next(ic, c, vc, vp, vm);
      m_cnt = m_cnt + 32'd1;
   endtask

   task automatic rand_instr();
      logic [3:0] ic;
      ic = 4'($urandom_range(1, 11));
      do_instr(ic, 1'b1, 1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, int'($urandom_range(0, 4)), 1'b0, 1'b0);
   endtask

   task automatic hold_halted(input int n);
      for (int k = 0; k < n; k++) begin
         start = 1'($urandom);
         tick();
         chk_cycle("halted_hold", 6'd0, 1'b0);
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
      cnd = 1'b0; valC = '0; valP = '0; valM = '0; mem_ack = 1'b0; dmem_error = 1'b0;
      @(negedge clk);
      do_reset(1'b0);

      // Directed: IRMOVQ, JXX taken/not taken, CALL with 3 wait cycles, RET.
      do_instr(4'h3, 1'b1, 1'b0, 1'b0, 64'h55, 64'hA, 64'h77, 0, 1'b0, 1'b0);
      do_instr(4'h7, 1'b1, 1'b0, 1'b1, 64'h100, 64'h9, 64'h0, 0, 1'b0, 1'b0);
      do_instr(4'h7, 1'b1, 1'b0, 1'b0, 64'h100, 64'h9, 64'h0, 0, 1'b0, 1'b0);
      do_instr(4'h8, 1'b1, 1'b0, 1'b0, 64'h40, 64'h12, 64'h0, 3, 1'b0, 1'b0);
      do_instr(4'h9, 1'b1, 1'b0, 1'b0, 64'h0, 64'h2, 64'h13, 0, 1'b0, 1'b0);

      // Random legal instruction stream, including PC wraparound values.
      for (int n = 0; n < 40; n++) rand_instr();
      do_instr(4'h6, 1'b1, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1'b0, 1'b0);

      // HALT: stat=HLT, pc and count frozen, start ignored.
      do_instr(4'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0);
      hold_halted(4);

      // Faults from AOK.
      do_reset(1'b0);
      rand_instr();
      do_instr(4'h3, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0);
      hold_halted(2);
      do_reset(1'b0);
      rand_instr();
      do_instr(4'hD, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0);
      hold_halted(2);
      do_reset(1'b0);
      rand_instr();
      do_instr(4'h5, 1'b1, 1'b0, 1'b0, 64'h0, 64'h20, 64'h30, 2, 1'b1, 1'b0);
      hold_halted(2);
      do_reset(1'b0);
      rand_instr();
      do_instr(4'hA, 1'b1, 1'b0, 1'b0, 64'h0, 64'h20, 64'h30, 0, 1'b0, 1'b1);
      hold_halted(2);

      // Longest permitted wait: ack on the 16th request cycle still succeeds.
      do_reset(1'b0);
      do_instr(4'h4, 1'b1, 1'b0, 1'b0, 64'h0, 64'h88, 64'h0, 15, 1'b0, 1'b0);
      rand_instr();

      // Asynchronous reset while mem_req is high.
      icode = 4'h8; instr_valid = 1'b1; imem_error = 1'b0; valC = 64'h1234;
      #1;
      chk_cycle("mid_fetch", 6'b000001, 1'b0);
      tick(); tick(); tick();
      chk_cycle("mid_mem", 6'b001000, 1'b1);
      do_reset(1'b1);
      rand_instr();

      // Random runs with occasional faults.
      for (int r = 0; r < 6; r++) begin
         do_reset(1'b0);
         for (int n = 0; n < 12 && !m_halted; n++) begin
            logic [3:0] ic;
            int sel;
            sel = int'($urandom_range(0, 19));
            ic = 4'($urandom_range(0, 11));
            do_instr(ic, sel != 1, sel == 0, 1'($urandom), {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom},
                     int'($urandom_range(0, 5)), sel == 2, sel == 3);
         end
         if (m_halted) hold_halted(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
